// File: rtl/pe_link_port.sv
// pe_link_port: router-side endpoint of the credit-based local link to one PE.
// TX path buffers router flits and forwards them to the PE while credits remain.
// RX path buffers PE flits for the router and returns one credit per flit drained.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module pe_link_port #(
  parameter int unsigned DATA_WIDTH  = `ROUTER_WIDTH,
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned RX_DEPTH    = 4,
  parameter int unsigned CREDIT_INIT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rt_in_valid,
  input  logic [DATA_WIDTH-1:0]              rt_in_data,
  output logic                               rt_in_ready,
  output logic                               pe_in_data_valid,
  output logic [DATA_WIDTH-1:0]              pe_in_data,
  input  logic                               pe_upstream_credit,
  input  logic                               pe_out_data_valid,
  input  logic [DATA_WIDTH-1:0]              pe_out_data,
  output logic                               pe_downstream_credit,
  output logic                               rt_out_valid,
  output logic [DATA_WIDTH-1:0]              rt_out_data,
  input  logic                               rt_out_ready,
  output logic [$clog2(CREDIT_INIT+1)-1:0]   credit_cnt,
  output logic                               link_err
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_PW = RX_AW + 1;
  localparam int unsigned CW    = $clog2(CREDIT_INIT + 1);

  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];

  logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;

  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_drop;

  logic [CW-1:0] credit_nxt;
  logic          credit_ovf;

  // FIFO status from wrap-bit pointer comparison
  always_comb begin
    tx_empty = (tx_wr_ptr == tx_rd_ptr);
    tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
               (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    rx_empty = (rx_wr_ptr == rx_rd_ptr);
    rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
               (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  end

  // Handshake and transfer qualifiers; ready/valid depend only on registered pointers
  always_comb begin
    rt_in_ready  = !tx_full;
    tx_push      = rt_in_valid && !tx_full;
    tx_pop       = !tx_empty && (credit_cnt != '0);
    rt_out_valid = !rx_empty;
    rt_out_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
    rx_pop       = !rx_empty && rt_out_ready;
    rx_push      = pe_out_data_valid && (!rx_full || rx_pop);
    rx_drop      = pe_out_data_valid && rx_full && !rx_pop;
  end

  // Credit counter next state; a return at the ceiling saturates and flags an error
  always_comb begin
    credit_nxt = credit_cnt;
    credit_ovf = 1'b0;
    if (tx_pop && !pe_upstream_credit) begin
      credit_nxt = credit_cnt - CW'(1);
    end else if (!tx_pop && pe_upstream_credit) begin
      if (credit_cnt >= CW'(CREDIT_INIT)) begin
        credit_ovf = 1'b1;
      end else begin
        credit_nxt = credit_cnt + CW'(1);
      end
    end
  end

  // FIFO storage writes; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= rt_in_data;
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= pe_out_data;
  end

  // Pointers, credits, registered PE-side outputs and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr            <= '0;
      tx_rd_ptr            <= '0;
      rx_wr_ptr            <= '0;
      rx_rd_ptr            <= '0;
      credit_cnt           <= CW'(CREDIT_INIT);
      pe_in_data_valid     <= 1'b0;
      pe_in_data           <= '0;
      pe_downstream_credit <= 1'b0;
      link_err             <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
      credit_cnt       <= credit_nxt;
      pe_in_data_valid <= tx_pop;
      if (tx_pop) pe_in_data <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
      pe_downstream_credit <= rx_pop;
      if (credit_ovf || rx_drop) link_err <= 1'b1;
    end
  end

endmodule
